hilo_unit: RTL
==============

HILO_UNIT -- requirements
Module: hilo_unit

Interface
REQ-001 SHALL have parameter TIMEOUT, default 40, the maximum BUSY cycles allowed before abort.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on the rising edge.
REQ-003 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-004 SHALL have port op_valid, input, 1, an EX-stage HI/LO op is present.
REQ-005 SHALL have port op, input, 3, the op code: 0 none, 1 MULT, 2 MULTU, 3 MTHI, 4 MTLO, 5 MFHI, 6 MFLO, 7 reserved (treated as none).
REQ-006 SHALL have port rs_data, input, 32, the first operand (multiplicand / MTHI / MTLO source).
REQ-007 SHALL have port rt_data, input, 32, the second operand (multiplier).
REQ-008 SHALL have port rd_data, output, 32, the MFHI/MFLO result.
REQ-009 SHALL have port rd_valid, output, 1, rd_data is valid this cycle.
REQ-010 SHALL have port stall, output, 1, hold the EX stage; op not consumed.
REQ-011 SHALL have port mul_enable, output, 1, the multiplier enable, held high for the whole operation.
REQ-012 SHALL have port mul_sign, output, 1, the multiplier signed-mode select.
REQ-013 SHALL have ports mul_a and mul_b, output, 32 each, the latched operands to the multiplier.
REQ-014 SHALL have port mul_product, input, 64, the multiplier result.
REQ-015 SHALL have port mul_ready, input, 1, the multiplier done flag; product is valid in that cycle.
REQ-016 SHALL have port busy, output, 1, a multiply is in flight.
REQ-017 SHALL have port err, output, 1, a sticky timeout flag.

Function
REQ-018 SHALL implement the FSM states IDLE and BUSY; mul_enable and busy SHALL equal (state==BUSY).
REQ-019 In IDLE, op_valid with MULT/MULTU SHALL latch rs_data into mul_a, rt_data into mul_b, and sign (1 for MULT, 0 for MULTU) into mul_sign, then go to BUSY next cycle.
REQ-020 In BUSY with mul_ready=1, the block SHALL write HI<=mul_product[63:32] and LO<=mul_product[31:0], then go to IDLE.
REQ-021 mul_enable SHALL be low for at least one cycle between consecutive multiplies, so a MULT arriving in the completion cycle is stalled and accepted from IDLE.
REQ-022 stall SHALL = op_valid & (op in 1..6) & (state==BUSY), combinationally; a stalled op SHALL have no side effect.
REQ-023 In IDLE, MTHI/MTLO SHALL write rs_data into HI/LO at the clock edge.
REQ-024 In IDLE, MFHI/MFLO SHALL drive HI/LO onto rd_data combinationally with rd_valid=1 in the same cycle.
REQ-025 rd_data SHALL be 0 when rd_valid=0.
REQ-026 An MFHI/MFLO following an MTHI/MTLO SHALL see the new value on the next cycle; HI/LO SHALL NOT be bypassed within the same cycle.
REQ-027 The BUSY cycle counter SHALL clear on entry to BUSY and increment each BUSY cycle.
REQ-028 If the counter reaches TIMEOUT without mul_ready, the block SHALL set err=1, leave HI/LO unchanged, and go to IDLE.
REQ-029 err SHALL clear only on reset.
REQ-030 mul_ready while in IDLE SHALL be ignored.
REQ-031 op values 0 and 7 SHALL never stall and SHALL have no effect.

Reset
REQ-032 Reset SHALL force state IDLE; HI, LO, mul_a, mul_b, mul_sign, counter and err to 0; and all outputs (rd_data, rd_valid, stall, mul_enable, busy) to 0 in the following cycle.
REQ-033 Reset SHALL take priority over every other event, including mid-BUSY and a coincident mul_ready; HI/LO SHALL NOT be written on that edge.

Verification (with a stub multiplier asserting mul_ready with the true product 3 cycles after mul_enable rises)
REQ-034 The bench SHALL cover: MULT rs=-7 (0xFFFFFFF9), rt=6 -> mul_sign=1, busy 3 cycles; then MFHI=0xFFFFFFFF and MFLO=0xFFFFFFD6.
REQ-035 The bench SHALL cover: MULTU rs=0xFFFFFFFF, rt=2 -> mul_sign=0; then HI=0x00000001 and LO=0xFFFFFFFE.
REQ-036 The bench SHALL cover: MFLO issued the cycle after a MULT -> stall=1 until the completion cycle, then rd_valid=1 with the new LO, and no earlier rd_valid.
REQ-037 The bench SHALL cover: MTHI 0x12345678 then MFHI next cycle -> rd_data=0x12345678 and stall=0 throughout.
REQ-038 The bench SHALL cover: stub never asserts mul_ready -> err=1 after 40 BUSY cycles, busy=0, and HI/LO unchanged.
REQ-039 The bench SHALL cover: reset asserted in the 2nd BUSY cycle -> the next cycle shows busy=0, mul_enable=0, HI=LO=0, err=0, and a late mul_ready is ignored.

Source files
------------

// File: rtl/hilo_unit.sv
// hilo_unit: HI/LO register file with a multiplier handshake, a busy timeout and MFHI/MFLO read-out.
module hilo_unit #(
  parameter int TIMEOUT = 40
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        op_valid,
  input  logic [2:0]  op,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  output logic [31:0] rd_data,
  output logic        rd_valid,
  output logic        stall,
  output logic        mul_enable,
  output logic        mul_sign,
  output logic [31:0] mul_a,
  output logic [31:0] mul_b,
  input  logic [63:0] mul_product,
  input  logic        mul_ready,
  output logic        busy,
  output logic        err
);
  localparam int CW = $clog2(TIMEOUT + 1);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t r_state, w_next;
  logic [CW-1:0] r_cnt;
  logic [31:0] r_hi, r_lo, r_mul_a, r_mul_b;
  logic r_mul_sign, r_err;
  logic w_busy, w_op_ok, w_idle_op, w_mul, w_done, w_timeout;
  assign w_busy    = r_state == BUSY;
  assign w_op_ok   = op_valid && op >= 3'd1 && op <= 3'd6;
  assign w_idle_op = w_op_ok && !w_busy;
  assign w_mul     = w_idle_op && (op == 3'd1 || op == 3'd2);
  assign w_done    = w_busy && mul_ready;
  // ready wins over timeout when both land in the last allowed cycle
  assign w_timeout = w_busy && !mul_ready && r_cnt == CW'(TIMEOUT - 1);
  always_comb begin
    w_next     = r_state;
    stall      = w_op_ok && w_busy;
    rd_valid   = w_idle_op && (op == 3'd5 || op == 3'd6);
    rd_data    = rd_valid ? (op == 3'd5 ? r_hi : r_lo) : 32'd0;
    busy       = w_busy;
    mul_enable = w_busy;
    w_next     = w_busy ? ((w_done || w_timeout) ? IDLE : BUSY) : (w_mul ? BUSY : IDLE);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_hi       <= '0;
      r_lo       <= '0;
      r_mul_a    <= '0;
      r_mul_b    <= '0;
      r_mul_sign <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_mul) begin
        r_mul_a    <= rs_data;
        r_mul_b    <= rt_data;
        r_mul_sign <= op == 3'd1;
        r_cnt      <= '0;
      end else if (w_busy) r_cnt <= r_cnt + 1'b1;
      if (w_done) {r_hi, r_lo} <= mul_product;
      else if (w_idle_op && op == 3'd3) r_hi <= rs_data;
      else if (w_idle_op && op == 3'd4) r_lo <= rs_data;
      if (w_timeout) r_err <= 1'b1;
    end
  end
  assign mul_a    = r_mul_a;
  assign mul_b    = r_mul_b;
  assign mul_sign = r_mul_sign;
  assign err      = r_err;
endmodule
